// File: rtl/encrypt_sched_if.sv
// Requester/response bundle for encrypt_sched: per-requester valid/ready with packed
// key/plaintext slices, plus the tagged ciphertext response channel.
interface encrypt_sched_if #(
  parameter int N_REQ = 4,
  parameter int TW    = $clog2(N_REQ),
  parameter int KW    = 32,
  parameter int BW    = 32
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*KW-1:0] req_k;
  logic [N_REQ*BW-1:0] req_m;
  logic                rsp_valid;
  logic [TW-1:0]       rsp_tag;
  logic [BW-1:0]       rsp_c;

  modport master (
    output req_valid, req_k, req_m,
    input  req_ready, rsp_valid, rsp_tag, rsp_c
  );

  modport slave (
    input  req_valid, req_k, req_m,
    output req_ready, rsp_valid, rsp_tag, rsp_c
  );
endinterface

// File: rtl/encrypt_sched.sv
// Round-robin scheduler feeding one pipelined encrypt core; tags ride alongside the core.
// Optional per-requester accept counters when ENCRYPT_SCHED_CNT_EN is defined.
`ifndef N_K
`define N_K 32
`endif
`ifndef N_B
`define N_B 32
`endif
`ifndef N_R
`define N_R 4
`endif

module encrypt_sched #(
  parameter int N_REQ = 4,
  parameter int TW    = $clog2(N_REQ),
  parameter int LAT   = `N_R,
  parameter int KW    = `N_K,
  parameter int BW    = `N_B
) (
  input  logic            clk,
  input  logic            rst,
  encrypt_sched_if.slave  bus,
  output logic [KW-1:0]   core_k,
  output logic [BW-1:0]   core_m,
  input  logic [BW-1:0]   core_c
`ifdef ENCRYPT_SCHED_CNT_EN
  ,
  output logic [N_REQ*16-1:0] cnt
`endif
);

  logic [TW-1:0]   ptr_q, ptr_d;
  logic            grant_any;
  logic [TW-1:0]   grant_idx;
  logic [N_REQ-1:0] grant_vec;
  logic [TW:0]     wrap_sum;
  logic [TW-1:0]   cand;

  logic [KW-1:0]   core_k_q, core_k_d;
  logic [BW-1:0]   core_m_q, core_m_d;

  // One extra stage beyond LAT covers the issue register, so the tag lines up with core_c.
  logic [LAT+1:0]  sh_v_q, sh_v_d;
  logic [TW-1:0]   sh_tag_q [LAT+2];
  logic [TW-1:0]   sh_tag_d [LAT+2];

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    wrap_sum  = '0;
    cand      = '0;
    for (int o = 0; o < N_REQ; o++) begin
      wrap_sum = {1'b0, ptr_q} + (TW+1)'(o);
      if (wrap_sum >= (TW+1)'(N_REQ)) begin
        wrap_sum = wrap_sum - (TW+1)'(N_REQ);
      end
      cand = wrap_sum[TW-1:0];
      if (!grant_any && bus.req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (rst) begin
      grant_any = 1'b0;
    end
    if (grant_any) begin
      grant_vec[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    core_k_d = core_k_q;
    core_m_d = core_m_q;
    if (grant_any) begin
      ptr_d    = (grant_idx == TW'(N_REQ - 1)) ? '0 : grant_idx + TW'(1);
      core_k_d = bus.req_k[grant_idx*KW +: KW];
      core_m_d = bus.req_m[grant_idx*BW +: BW];
    end
  end

  always_comb begin
    sh_v_d      = '0;
    sh_v_d[0]   = grant_any;
    sh_tag_d[0] = grant_idx;
    for (int j = 1; j <= LAT + 1; j++) begin
      sh_v_d[j]   = sh_v_q[j-1];
      sh_tag_d[j] = sh_tag_q[j-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      core_k_q <= '0;
      core_m_q <= '0;
      sh_v_q   <= '0;
      for (int j = 0; j <= LAT + 1; j++) begin
        sh_tag_q[j] <= '0;
      end
    end else begin
      ptr_q    <= ptr_d;
      core_k_q <= core_k_d;
      core_m_q <= core_m_d;
      sh_v_q   <= sh_v_d;
      for (int j = 0; j <= LAT + 1; j++) begin
        sh_tag_q[j] <= sh_tag_d[j];
      end
    end
  end

  assign bus.req_ready = grant_vec;
  assign core_k        = core_k_q;
  assign core_m        = core_m_q;
  assign bus.rsp_valid = sh_v_q[LAT+1];
  assign bus.rsp_tag   = sh_tag_q[LAT+1];
  assign bus.rsp_c     = core_c;

`ifdef ENCRYPT_SCHED_CNT_EN
  logic [N_REQ-1:0][15:0] cnt_q, cnt_d;

  // Counters saturate rather than wrap so a long-running requester never reads as idle.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_vec[i] && (cnt_q[i] != 16'hFFFF)) begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
`endif

endmodule

// File: tb/tb_encrypt_sched.sv
// Randomised scoreboard bench for encrypt_sched with a behavioural core and arbiter model.
// Build with ENCRYPT_SCHED_CNT_EN defined to also exercise the accept counters.
module tb_encrypt_sched;
  localparam int N_REQ  = 4;
  localparam int TW     = 2;
  localparam int LAT    = 4;
  localparam int KW     = 32;
  localparam int BW     = 32;
  localparam int PERIOD = 10;

  typedef struct {
    logic [TW-1:0] tag;
    logic [BW-1:0] c;
    time           due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [KW-1:0] core_k;
  logic [BW-1:0] core_m;
  logic [BW-1:0] core_c;
`ifdef ENCRYPT_SCHED_CNT_EN
  logic [N_REQ*16-1:0] cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  exp_t sbq[$];
  exp_t mon_e;
  int dut_grants[$];

  int m_ptr;
  int m_cnt [N_REQ];
  logic [N_REQ-1:0] pend;
  logic [KW-1:0] pk [N_REQ];
  logic [BW-1:0] pm [N_REQ];
  logic [BW-1:0] pipe [LAT+1];

  always #(PERIOD/2) clk = ~clk;

  encrypt_sched_if #(.N_REQ(N_REQ), .TW(TW), .KW(KW), .BW(BW)) bus ();

  encrypt_sched #(.N_REQ(N_REQ), .TW(TW), .LAT(LAT), .KW(KW), .BW(BW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .core_k (core_k),
    .core_m (core_m),
    .core_c (core_c)
`ifdef ENCRYPT_SCHED_CNT_EN
    ,
    .cnt    (cnt)
`endif
  );

  function automatic logic [BW-1:0] cipher(input logic [KW-1:0] k, input logic [BW-1:0] m);
    return ((m ^ k) * 32'h9E3779B1) + {k[7:0], k[31:8]};
  endfunction

  // Stand-in core: input stable before edge e gives ciphertext after edge e+LAT.
  always @(posedge clk) begin
    pipe[0] <= cipher(core_k, core_m);
    for (int j = 1; j <= LAT; j++) pipe[j] <= pipe[j-1];
  end
  assign core_c = pipe[LAT];

  function automatic int model_grant(input logic [N_REQ-1:0] v, input int p);
    for (int o = 0; o < N_REQ; o++) begin
      if (v[(p + o) % N_REQ]) return (p + o) % N_REQ;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One cycle of traffic: idle requesters in mask raise valid with pct% chance; pending ones hold.
  task automatic applyStimulus(input logic [N_REQ-1:0] mask, input int pct);
    int g;
    logic [N_REQ*KW-1:0] kv;
    logic [N_REQ*BW-1:0] mv;
    logic [N_REQ-1:0] exp_rdy;
    @(negedge clk);
    #2;
    for (int i = 0; i < N_REQ; i++) begin
      if (!pend[i] && mask[i] && ($urandom_range(99) < pct)) begin
        pend[i] = 1'b1;
        pk[i]   = $urandom;
        pm[i]   = $urandom;
      end
      kv[i*KW +: KW] = pk[i];
      mv[i*BW +: BW] = pm[i];
    end
    bus.req_valid = pend;
    bus.req_k     = kv;
    bus.req_m     = mv;
    #1;
    g = model_grant(pend, m_ptr);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    checkOutput("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    for (int i = 0; i < N_REQ; i++) begin
      if (bus.req_ready[i] === 1'b1) dut_grants.push_back(i);
    end
    @(posedge clk);
    if (g >= 0) begin
      sbq.push_back('{tag: TW'(g), c: cipher(pk[g], pm[g]),
                      due: $time + (LAT + 1) * PERIOD + PERIOD / 2});
      pend[g] = 1'b0;
      m_ptr   = (g + 1) % N_REQ;
      if (m_cnt[g] < 65535) m_cnt[g]++;
    end
  endtask

  task automatic doReset(input int n);
    @(negedge clk);
    #2;
    rst           = 1'b1;
    bus.req_valid = '1;
    pend          = '0;
    sbq.delete();
    m_ptr = 0;
    for (int i = 0; i < N_REQ; i++) m_cnt[i] = 0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset req_ready", 64'(bus.req_ready), 64'd0);
    checkOutput("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("reset rsp_tag", 64'(bus.rsp_tag), 64'd0);
    checkOutput("reset core_k", 64'(core_k), 64'd0);
    checkOutput("reset core_m", 64'(core_m), 64'd0);
    #1;
    rst           = 1'b0;
    bus.req_valid = '0;
  endtask

  task automatic drain();
    for (int n = 0; n < 2 * N_REQ && pend != '0; n++) applyStimulus('0, 0);
    checkOutput("drain pending", 64'(pend), 64'd0);
  endtask

  task automatic check_grants(input string name, input int exp_list[$]);
    checkOutput({name, " count"}, 64'(dut_grants.size()), 64'(exp_list.size()));
    for (int i = 0; i < exp_list.size() && i < dut_grants.size(); i++) begin
      checkOutput(name, 64'(dut_grants[i]), 64'(exp_list[i]));
    end
    dut_grants.delete();
  endtask

  // Monitor: pops the scoreboard on every response and flags late, missing or spurious ones.
  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checkOutput("spurious rsp_valid", 64'd1, 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        checkOutput("rsp_tag", 64'(bus.rsp_tag), 64'(mon_e.tag));
        checkOutput("rsp_c", 64'(bus.rsp_c), 64'(mon_e.c));
        checkOutput("rsp time", 64'($time), 64'(mon_e.due));
      end
    end else if (bus.rsp_valid !== 1'b0) begin
      checkOutput("rsp_valid known", 64'(bus.rsp_valid), 64'd0);
    end else if (sbq.size() > 0 && sbq[0].due <= $time) begin
      mon_e = sbq.pop_front();
      checkOutput("missing rsp", 64'($time), 64'(mon_e.due));
    end
  end

  initial begin
    #(PERIOD * 50000);
    $display("[TB] FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int q[$];
    rst           = 1'b1;
    pend          = '0;
    m_ptr         = 0;
    bus.req_valid = '0;
    bus.req_k     = '0;
    bus.req_m     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pk[i] = '0;
      pm[i] = '0;
      m_cnt[i] = 0;
    end
    doReset(2);
    dut_grants.delete();

    // Requester 0 alone, back-to-back.
    for (int i = 0; i < 8; i++) applyStimulus(4'b0001, 100);
    q = '{0, 0, 0, 0, 0, 0, 0, 0};
    check_grants("single rr0", q);
    drain();

    // All requesters valid from ptr=0: strict rotation.
    doReset(1);
    dut_grants.delete();
    for (int i = 0; i < 8; i++) applyStimulus(4'b1111, 100);
    q = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_grants("rotation", q);
    drain();

    // Sparse pattern 1010 from ptr=0.
    doReset(1);
    dut_grants.delete();
    for (int i = 0; i < 3; i++) applyStimulus(4'b1010, 100);
    q = '{1, 3, 1};
    check_grants("pattern 1010", q);
    drain();

    // Gapped traffic, one accept every third cycle.
    for (int i = 0; i < 15; i++) applyStimulus((i % 3 == 0) ? 4'b0001 : 4'b0000, 100);
    drain();
    repeat (LAT + 3) applyStimulus('0, 0);

    // Reset with LAT requests in flight, then confirm silence and ptr back at 0.
    for (int i = 0; i < LAT; i++) applyStimulus(4'b1111, 100);
    doReset(2);
    repeat (LAT + 3) applyStimulus('0, 0);
    dut_grants.delete();
    applyStimulus(4'b1111, 100);
    q = '{0};
    check_grants("post-reset first grant", q);
    drain();

    // Random traffic with random masks.
    for (int i = 0; i < 400; i++) applyStimulus(N_REQ'($urandom), int'($urandom_range(100)));
    drain();
    dut_grants.delete();

`ifdef ENCRYPT_SCHED_CNT_EN
    doReset(1);
    for (int i = 0; i < 5; i++) applyStimulus(4'b0100, 100);
    drain();
    @(negedge clk);
    for (int i = 0; i < N_REQ; i++) checkOutput("cnt", 64'(cnt[i*16 +: 16]), 64'(m_cnt[i]));
    force dut.cnt_q = {16'h0, 16'hFFFF, 16'h0, 16'h0};
    #1;
    release dut.cnt_q;
    m_cnt[2] = 65535;
    applyStimulus(4'b0100, 100);
    drain();
    @(negedge clk);
    for (int i = 0; i < N_REQ; i++) checkOutput("cnt saturate", 64'(cnt[i*16 +: 16]), 64'(m_cnt[i]));
    dut_grants.delete();
`endif

    repeat (LAT + 4) applyStimulus('0, 0);
    checkOutput("scoreboard empty", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end

endmodule
